sgd_data_feeder: RTL

SGD_DATA_FEEDER -- requirements
Module: sgd_data_feeder

---
 rtl/sgd_data_feeder.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/sgd_data_feeder.sv
// Loads a serial word stream into a row store (Y plus features per row) and serves rows to the trainer.
// Optional macro FEEDER_ZERO_PAD_EN: clear unused feature slots when a row is committed.
module sgd_data_feeder #(
  parameter int ADDR_WIDTH   = 12,
  parameter int MAX_FEATURES = 15,
  parameter int LENGTH       = 16,
  parameter int DATA_WIDTH   = LENGTH*(MAX_FEATURES+1),
  parameter int DP           = 10
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         load_start,
  input  logic [3:0]                   feat,
  input  logic [ADDR_WIDTH-1:0]        data_points,
  input  logic [LENGTH-1:0]            in_word,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ADDR_WIDTH-1:0]        addr,
  output logic signed [DATA_WIDTH-1:0] data,
  output logic                         loaded,
  output logic                         err
);
  localparam int NS  = MAX_FEATURES + 1;
  localparam int WCW = $clog2(NS + 1);
  localparam int DPW = (DP > 1) ? $clog2(DP) : 1;
`ifdef FEEDER_ZERO_PAD_EN
  localparam bit ZERO_PAD = 1'b1;
`else
  localparam bit ZERO_PAD = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, SERVE, ERR} state_e;

  state_e                     state_q, state_d;
  logic [WCW-1:0]             feat_q, feat_d, word_cnt_q, word_cnt_d;
  logic [ADDR_WIDTH-1:0]      npts_q, npts_d, row_cnt_q, row_cnt_d;
  logic [NS-1:0][LENGTH-1:0]  rowbuf_q, rowbuf_d;
  logic [DATA_WIDTH-1:0]      data_q, data_d;
  logic                       loaded_q, loaded_d, err_q, err_d;

  logic                       hs, commit, dp_bad;
  logic [WCW-1:0]             feat_clamp;
  logic [NS-1:0][LENGTH-1:0]  rd_words;
  logic [DPW-1:0]             wr_idx, rd_idx;

  assign in_ready = (state_q == LOAD);
  assign data     = data_q;
  assign loaded   = loaded_q;
  assign err      = err_q;

  // A restart request wins over a word offered in the same cycle.
  assign hs     = (state_q == LOAD) && in_valid && !load_start;
  assign commit = hs && (word_cnt_q == feat_q) && !RST;
  assign wr_idx = row_cnt_q[DPW-1:0];
  assign rd_idx = addr[DPW-1:0];
  assign dp_bad = (data_points == '0) || (32'(data_points) > DP);

  always_comb begin
    feat_clamp = WCW'(MAX_FEATURES);
    if (32'(feat) <= MAX_FEATURES) feat_clamp = WCW'(feat);
  end

  always_comb begin
    state_d    = state_q;
    feat_d     = feat_q;
    npts_d     = npts_q;
    word_cnt_d = word_cnt_q;
    row_cnt_d  = row_cnt_q;
    rowbuf_d   = rowbuf_q;
    err_d      = err_q;
    case (state_q)
      IDLE, LOAD, SERVE: begin
        if (load_start) begin
          if (dp_bad) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            state_d    = LOAD;
            feat_d     = feat_clamp;
            npts_d     = data_points;
            word_cnt_d = '0;
            row_cnt_d  = '0;
          end
        end else if (hs) begin
          for (int j = 0; j < NS; j++)
            if (word_cnt_q == WCW'(j)) rowbuf_d[j] = in_word;
          if (word_cnt_q == feat_q) begin
            word_cnt_d = '0;
            row_cnt_d  = row_cnt_q + ADDR_WIDTH'(1);
            if (row_cnt_q == npts_q - ADDR_WIDTH'(1)) state_d = SERVE;
          end else begin
            word_cnt_d = word_cnt_q + WCW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    loaded_d = (state_q == SERVE) && !load_start;
    data_d   = '0;
    if (loaded_d && (addr < npts_q))
      for (int j = 0; j < NS; j++)
        data_d[DATA_WIDTH-1-LENGTH*j -: LENGTH] = rd_words[j];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      feat_q     <= '0;
      npts_q     <= '0;
      word_cnt_q <= '0;
      row_cnt_q  <= '0;
      rowbuf_q   <= '0;
      data_q     <= '0;
      loaded_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      feat_q     <= feat_d;
      npts_q     <= npts_d;
      word_cnt_q <= word_cnt_d;
      row_cnt_q  <= row_cnt_d;
      rowbuf_q   <= rowbuf_d;
      data_q     <= data_d;
      loaded_q   <= loaded_d;
      err_q      <= err_d;
    end
  end

  // One storage column per slot; the last word bypasses the row buffer on commit.
  for (genvar j = 0; j < NS; j++) begin : g_slot
    logic [LENGTH-1:0] slot_mem [DP];
    logic [LENGTH-1:0] wdata;
    logic              we;
    always_comb begin
      wdata = (word_cnt_q == WCW'(j)) ? in_word : rowbuf_q[j];
      we    = commit && ((WCW'(j) <= feat_q) || ZERO_PAD);
      if (WCW'(j) > feat_q) wdata = '0;
    end
    always_ff @(posedge CLK) begin
      if (we) slot_mem[wr_idx] <= wdata;
    end
    assign rd_words[j] = slot_mem[rd_idx];
  end
endmodule
